// File: rtl/mult_div_unit_pkg.sv
// Purpose: shared MD op encodings and default latencies for the mult/div unit and the hazard unit.
// Latency: n/a (definitions only).
// Backpressure: n/a; the hazard unit uses the cycle counts to match the Busy window.
package mult_div_unit_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'b0000,
        MD_MULT  = 4'b0001,
        MD_MULTU = 4'b0010,
        MD_DIV   = 4'b0011,
        MD_DIVU  = 4'b0100,
        MD_MTHI  = 4'b0101,
        MD_MTLO  = 4'b0110
    } md_op_e;

    localparam int MULT_CYCLES_DEFAULT = 5;
    localparam int DIV_CYCLES_DEFAULT  = 10;

    // Wide enough for any practical Busy window.
    localparam int CNT_W = 8;

endpackage

// File: rtl/mult_div_unit_md_divider.sv
// Purpose: combinational signed/unsigned 32-bit quotient and remainder with MIPS divide-by-zero rules.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller samples the result whenever it needs it.
module md_divider (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_signed,
    output logic [31:0] quo,
    output logic [31:0] rem
);

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    // Divide magnitudes, then restore signs: quotient truncates toward zero, remainder follows a.
    // 0x80000000 / -1 falls out naturally: both magnitudes stay 0x80000000 and 1, signs cancel.
    always_comb begin
        a_neg   = is_signed & a[31];
        b_neg   = is_signed & b[31];
        a_mag   = a_neg ? (~a + 32'd1) : a;
        b_mag   = b_neg ? (~b + 32'd1) : b;
        // Keep the divider operand nonzero so the unused path never divides by zero.
        divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag   = a_mag / divisor;
        r_mag   = a_mag % divisor;
        quo     = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem     = a_neg ? (~r_mag + 32'd1) : r_mag;
        if (b == 32'd0) begin
            quo = 32'hFFFF_FFFF;
            rem = a;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Purpose: EX-stage multiply/divide unit owning architectural HI/LO; MTHI/MTLO write immediately.
// Latency: MULT/MULTU hold Busy MULT_CYCLES cycles, DIV/DIVU DIV_CYCLES cycles; HI/LO update as Busy falls.
// Backpressure: Busy stalls MD-class instructions in ID; Start while Busy or with Cancel is dropped.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDOp,
    input  logic        Start,
    input  logic        Cancel,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        pend_hi;
    logic [31:0]        pend_lo;

    logic               is_mul;
    logic               is_div;
    logic               is_mt;
    logic               accept;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        div_quo;
    logic [31:0]        div_rem;
    logic [31:0]        nxt_hi;
    logic [31:0]        nxt_lo;
    logic [CNT_W-1:0]   load_cnt;

    md_divider u_div (
        .a         (A),
        .b         (B),
        .is_signed (MDOp == MD_DIV),
        .quo       (div_quo),
        .rem       (div_rem)
    );

    // Decode the op, gate acceptance, and form the result that will sit in the pending registers.
    always_comb begin
        is_mul   = (MDOp == MD_MULT) || (MDOp == MD_MULTU);
        is_div   = (MDOp == MD_DIV)  || (MDOp == MD_DIVU);
        is_mt    = (MDOp == MD_MTHI) || (MDOp == MD_MTLO);
        accept   = Start & ~Cancel & ~Busy & (is_mul | is_div | is_mt);
        prod_s   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u   = {32'd0, A} * {32'd0, B};
        nxt_hi   = div_rem;
        nxt_lo   = div_quo;
        load_cnt = CNT_W'(DIV_CYCLES);
        if (MDOp == MD_MULT) begin
            nxt_hi   = prod_s[63:32];
            nxt_lo   = prod_s[31:0];
            load_cnt = CNT_W'(MULT_CYCLES);
        end else if (MDOp == MD_MULTU) begin
            nxt_hi   = prod_u[63:32];
            nxt_lo   = prod_u[31:0];
            load_cnt = CNT_W'(MULT_CYCLES);
        end
    end

    // Control FSM: IDLE accepts ops, RUN counts down and commits the pending result on the last cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            Busy    <= 1'b0;
            HI      <= '0;
            LO      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (MDOp == MD_MTHI) begin
                            HI <= A;
                        end else if (MDOp == MD_MTLO) begin
                            LO <= A;
                        end else begin
                            pend_hi <= nxt_hi;
                            pend_lo <= nxt_lo;
                            cnt     <= load_cnt;
                            Busy    <= 1'b1;
                            state   <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // Cancel is ignored here: an accepted op always runs to completion.
                    if (cnt == CNT_W'(1)) begin
                        HI    <= pend_hi;
                        LO    <= pend_lo;
                        Busy  <= 1'b0;
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
